// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_control_unit
// Brief    : Registered RV32I(+M) decode stage with multi-cycle MUL/DIV hold.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_control_unit #(
    parameter int M_EXT    = 1,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          opcode,
    input  logic [2:0]          fun_3,
    input  logic [6:0]          fun_7,
    input  logic                stall_in,
    input  logic                flush,
    output logic                out_valid,
    output logic                d_mem_r,
    output logic                d_mem_w,
    output logic                jump,
    output logic                branch,
    output logic                wrten_reg,
    output logic                mux_complmnt,
    output logic                mux_d_mem,
    output logic                mux_inp_1,
    output logic                mux_inp_2,
    output logic [1:0]          mux_result,
    output logic [2:0]          mux_wire_module,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal,
    output logic                busy
);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_F7_MULDIV = 7'b0000001;

    localparam int c_MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int c_CNT_W   = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_LAT - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, MULDIV = 1'b1} state_t;

    typedef struct packed {
        logic                out_valid;
        logic                d_mem_r;
        logic                d_mem_w;
        logic                jump;
        logic                branch;
        logic                wrten_reg;
        logic                mux_complmnt;
        logic                mux_d_mem;
        logic                mux_inp_1;
        logic                mux_inp_2;
        logic [1:0]          mux_result;
        logic [2:0]          mux_wire_module;
        logic [ALU_OP_W-1:0] alu_op;
        logic                illegal;
    } ctrl_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_busy;
    logic [2:0]          r_pend_f3;
    ctrl_t               r_ctrl;
    ctrl_t               w_dec;
    ctrl_t               w_mdone;
    logic                w_accept;
    logic                w_is_m;
    logic                w_multi;
    logic [c_CNT_W-1:0]  w_lat_m1;

    assign in_ready = (r_state == IDLE) & ~stall_in & ~flush;
    assign w_accept = in_valid & in_ready;
    assign w_is_m   = (opcode == c_OP_OP) && (fun_7 == c_F7_MULDIV);
    assign w_lat_m1 = fun_3[2] ? c_DIV_LOAD : c_MUL_LOAD;
    // A latency of one needs no wait state and takes the single-cycle path.
    assign w_multi  = w_is_m && (M_EXT != 0) && (w_lat_m1 != '0);

    always_comb begin
        w_dec           = '0;
        w_dec.out_valid = 1'b1;
        case (opcode)
            c_OP_LUI: begin
                w_dec.wrten_reg = 1'b1; w_dec.mux_d_mem = 1'b1;
                w_dec.mux_result = 2'd1; w_dec.mux_wire_module = 3'd3;
            end
            c_OP_AUIPC: begin
                w_dec.wrten_reg = 1'b1; w_dec.mux_d_mem = 1'b1; w_dec.mux_result = 2'd2;
                w_dec.mux_inp_1 = 1'b1; w_dec.mux_inp_2 = 1'b1; w_dec.mux_wire_module = 3'd3;
            end
            c_OP_JAL: begin
                w_dec.jump = 1'b1; w_dec.wrten_reg = 1'b1; w_dec.mux_d_mem = 1'b1;
                w_dec.mux_result = 2'd3; w_dec.mux_inp_1 = 1'b1; w_dec.mux_inp_2 = 1'b1;
                w_dec.mux_wire_module = 3'd1;
            end
            c_OP_JALR: begin
                w_dec.jump = 1'b1; w_dec.wrten_reg = 1'b1; w_dec.mux_d_mem = 1'b1;
                w_dec.mux_result = 2'd3; w_dec.mux_inp_2 = 1'b1; w_dec.mux_wire_module = 3'd4;
            end
            c_OP_BRANCH: begin
                w_dec.branch = 1'b1; w_dec.mux_complmnt = 1'b1;
            end
            c_OP_LOAD: begin
                w_dec.d_mem_r = 1'b1; w_dec.wrten_reg = 1'b1; w_dec.mux_result = 2'd2;
                w_dec.mux_inp_2 = 1'b1; w_dec.mux_wire_module = 3'd4;
            end
            c_OP_STORE: begin
                w_dec.d_mem_w = 1'b1; w_dec.mux_result = 2'd2;
                w_dec.mux_inp_2 = 1'b1; w_dec.mux_wire_module = 3'd2;
            end
            c_OP_IMM: begin
                w_dec.wrten_reg = 1'b1; w_dec.mux_d_mem = 1'b1; w_dec.mux_result = 2'd2;
                w_dec.mux_inp_2 = 1'b1; w_dec.mux_wire_module = 3'd4;
                w_dec.alu_op = ALU_OP_W'({1'b0, fun_3});
            end
            c_OP_OP: begin
                if (fun_7 != c_F7_MULDIV) begin
                    w_dec.wrten_reg = 1'b1; w_dec.mux_d_mem = 1'b1; w_dec.mux_result = 2'd2;
                    w_dec.alu_op = ALU_OP_W'({1'b0, fun_3});
                    w_dec.mux_complmnt = fun_7[5];
                end else if (M_EXT != 0) begin
                    w_dec.wrten_reg = 1'b1; w_dec.mux_d_mem = 1'b1; w_dec.mux_result = 2'd2;
                    w_dec.alu_op = ALU_OP_W'({1'b1, fun_3});
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            default: w_dec.illegal = 1'b1;
        endcase
    end

    // Completion bundle is rebuilt from the captured fun_3 so that input
    // changes while the op is in flight cannot leak into the result.
    always_comb begin
        w_mdone            = '0;
        w_mdone.out_valid  = 1'b1;
        w_mdone.wrten_reg  = 1'b1;
        w_mdone.mux_d_mem  = 1'b1;
        w_mdone.mux_result = 2'd2;
        w_mdone.alu_op     = ALU_OP_W'({1'b1, r_pend_f3});
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_pend_f3 <= '0;
            r_ctrl    <= '0;
        end else if (flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_ctrl  <= '0;
        end else if (!stall_in) begin
            case (r_state)
                IDLE: begin
                    if (w_accept && w_multi) begin
                        r_state   <= MULDIV;
                        r_busy    <= 1'b1;
                        r_cnt     <= w_lat_m1;
                        r_pend_f3 <= fun_3;
                        r_ctrl    <= '0;
                    end else if (w_accept) begin
                        r_ctrl <= w_dec;
                    end else begin
                        r_ctrl <= '0;
                    end
                end
                MULDIV: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ctrl  <= w_mdone;
                    end else begin
                        r_cnt  <= r_cnt - 1'b1;
                        r_ctrl <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ctrl  <= '0;
                end
            endcase
        end
    end

    assign out_valid       = r_ctrl.out_valid;
    assign d_mem_r         = r_ctrl.d_mem_r;
    assign d_mem_w         = r_ctrl.d_mem_w;
    assign jump            = r_ctrl.jump;
    assign branch          = r_ctrl.branch;
    assign wrten_reg       = r_ctrl.wrten_reg;
    assign mux_complmnt    = r_ctrl.mux_complmnt;
    assign mux_d_mem       = r_ctrl.mux_d_mem;
    assign mux_inp_1       = r_ctrl.mux_inp_1;
    assign mux_inp_2       = r_ctrl.mux_inp_2;
    assign mux_result      = r_ctrl.mux_result;
    assign mux_wire_module = r_ctrl.mux_wire_module;
    assign alu_op          = r_ctrl.alu_op;
    assign illegal         = r_ctrl.illegal;
    assign busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_control_unit
// Brief    : Scoreboard bench for pipelined_control_unit (default and M_EXT=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_control_unit;

    localparam int c_MUL_LAT = 2;
    localparam int c_DIV_LAT = 32;
    localparam logic [6:0] c_LUI = 7'b0110111, c_AUIPC = 7'b0010111, c_JAL = 7'b1101111;
    localparam logic [6:0] c_JALR = 7'b1100111, c_BR = 7'b1100011, c_LOAD = 7'b0000011;
    localparam logic [6:0] c_STORE = 7'b0100011, c_IMM = 7'b0010011, c_OP = 7'b0110011;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic in_valid, stall_in, flush;
    logic [6:0] opcode, fun_7;
    logic [2:0] fun_3;

    logic a_ready, a_valid, a_mr, a_mw, a_j, a_b, a_wr, a_cp, a_dm, a_i1, a_i2, a_ill, a_busy;
    logic [1:0] a_res;
    logic [2:0] a_wm;
    logic [3:0] a_alu;
    logic b_ready, b_valid, b_mr, b_mw, b_j, b_b, b_wr, b_cp, b_dm, b_i1, b_i2, b_ill, b_busy;
    logic [1:0] b_res;
    logic [2:0] b_wm;
    logic [3:0] b_alu;

    wire [18:0] got_a = {a_mr, a_mw, a_j, a_b, a_wr, a_cp, a_dm, a_i1, a_i2, a_res, a_wm, a_alu, a_ill};
    wire [18:0] got_b = {b_mr, b_mw, b_j, b_b, b_wr, b_cp, b_dm, b_i1, b_i2, b_res, b_wm, b_alu, b_ill};

    pipelined_control_unit #(.M_EXT(1), .MUL_LAT(c_MUL_LAT), .DIV_LAT(c_DIV_LAT), .ALU_OP_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(a_ready),
        .opcode(opcode), .fun_3(fun_3), .fun_7(fun_7), .stall_in(stall_in), .flush(flush),
        .out_valid(a_valid), .d_mem_r(a_mr), .d_mem_w(a_mw), .jump(a_j), .branch(a_b),
        .wrten_reg(a_wr), .mux_complmnt(a_cp), .mux_d_mem(a_dm), .mux_inp_1(a_i1),
        .mux_inp_2(a_i2), .mux_result(a_res), .mux_wire_module(a_wm), .alu_op(a_alu),
        .illegal(a_ill), .busy(a_busy));

    pipelined_control_unit #(.M_EXT(0), .MUL_LAT(c_MUL_LAT), .DIV_LAT(c_DIV_LAT), .ALU_OP_W(4)) dut_nom (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(b_ready),
        .opcode(opcode), .fun_3(fun_3), .fun_7(fun_7), .stall_in(stall_in), .flush(flush),
        .out_valid(b_valid), .d_mem_r(b_mr), .d_mem_w(b_mw), .jump(b_j), .branch(b_b),
        .wrten_reg(b_wr), .mux_complmnt(b_cp), .mux_d_mem(b_dm), .mux_inp_1(b_i1),
        .mux_inp_2(b_i2), .mux_result(b_res), .mux_wire_module(b_wm), .alu_op(b_alu),
        .illegal(b_ill), .busy(b_busy));

    always #5 CLK = ~CLK;

    typedef struct {
        int          when;
        logic [18:0] bits;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    logic held    = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference decode taken straight from the opcode table.
    function automatic logic [18:0] exp_bundle(input logic [6:0] op, input logic [2:0] f3,
                                               input logic [6:0] f7, input bit mext);
        logic mr, mw, j, b, wr, cp, dm, i1, i2, ill;
        logic [1:0] res;
        logic [2:0] wm;
        logic [3:0] alu;
        {mr, mw, j, b, wr, cp, dm, i1, i2, ill} = '0;
        res = '0; wm = '0; alu = '0;
        case (op)
            c_LUI:   begin wr = 1; dm = 1; res = 1; wm = 3; end
            c_AUIPC: begin wr = 1; dm = 1; res = 2; i1 = 1; i2 = 1; wm = 3; end
            c_JAL:   begin j = 1; wr = 1; dm = 1; res = 3; i1 = 1; i2 = 1; wm = 1; end
            c_JALR:  begin j = 1; wr = 1; dm = 1; res = 3; i2 = 1; wm = 4; end
            c_BR:    begin b = 1; cp = 1; end
            c_LOAD:  begin mr = 1; wr = 1; res = 2; i2 = 1; wm = 4; end
            c_STORE: begin mw = 1; res = 2; i2 = 1; wm = 2; end
            c_IMM:   begin wr = 1; dm = 1; res = 2; i2 = 1; wm = 4; alu = {1'b0, f3}; end
            c_OP: begin
                if (f7 == 7'b0000001) begin
                    if (mext) begin wr = 1; dm = 1; res = 2; alu = {1'b1, f3}; end
                    else ill = 1;
                end else begin
                    wr = 1; dm = 1; res = 2; alu = {1'b0, f3}; cp = f7[5];
                end
            end
            default: ill = 1;
        endcase
        return {mr, mw, j, b, wr, cp, dm, i1, i2, res, wm, alu, ill};
    endfunction

    always @(posedge CLK) begin
        cyc  <= cyc + 1;
        held <= stall_in & ~flush;
    end

    // A new result is any valid cycle not produced by a stalled edge.
    always @(negedge CLK) begin
        if (!RESET && a_valid && !held) begin
            if (sb.size() == 0) begin
                check_val("spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("out_cycle", cyc, e.when);
                check_val("bundle", got_a, e.bits);
            end
        end
    end

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input int extra, input bit push);
        int lat;
        @(posedge CLK); #1;
        check_val("ready_before_issue", a_ready, 1);
        in_valid = 1'b1; opcode = op; fun_3 = f3; fun_7 = f7;
        lat = 0;
        if (op == c_OP && f7 == 7'b0000001) lat = f3[2] ? c_DIV_LAT : c_MUL_LAT;
        if (push) sb.push_back('{cyc + 1 + lat + extra, exp_bundle(op, f3, f7, 1'b1)});
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(posedge CLK); #1;
        in_valid = 1'b0; opcode = 7'h7f; fun_3 = 3'h7; fun_7 = 7'h00;
        while (sb.size() != 0 && n < 100) begin
            @(posedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            check_val("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        in_valid = 0; stall_in = 0; flush = 0; opcode = 0; fun_3 = 0; fun_7 = 0;
        repeat (2) @(negedge CLK);
        check_val("reset_outputs", {a_valid, a_busy, got_a}, 0);
        check_val("reset_ready", a_ready, 1);
        RESET = 1'b0;
        @(negedge CLK);
        check_val("idle_after_reset", {a_valid, a_busy, a_ready}, 3'b001);

        issue(c_LOAD, 3'b010, 7'h00, 0, 1);
        drain();
        issue(c_OP, 3'b000, 7'b0100000, 0, 1);
        drain();

        issue(c_LUI, 3'b011, 7'h11, 0, 1);
        issue(c_AUIPC, 3'b000, 7'h00, 0, 1);
        issue(c_JAL, 3'b101, 7'h7f, 0, 1);
        issue(c_JALR, 3'b000, 7'h00, 0, 1);
        issue(c_BR, 3'b001, 7'h00, 0, 1);
        issue(c_STORE, 3'b010, 7'h00, 0, 1);
        issue(c_IMM, 3'b101, 7'h20, 0, 1);
        issue(c_OP, 3'b111, 7'h00, 0, 1);
        issue(7'b1111111, 3'b000, 7'h00, 0, 1);
        drain();

        // Stall holds a finished single-cycle bundle, then a bubble follows.
        issue(c_LUI, 3'b000, 7'h00, 0, 1);
        @(posedge CLK); #1;
        in_valid = 1'b0; stall_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check_val("stall_hold", {a_valid, got_a}, {1'b1, exp_bundle(c_LUI, 3'b000, 7'h00, 1'b1)});
            check_val("stall_not_ready", a_ready, 0);
        end
        stall_in = 1'b0;
        @(negedge CLK);
        check_val("bubble", {a_valid, a_busy, got_a}, 0);

        // DIV: busy for 32 edges, fields altered while in flight.
        issue(c_OP, 3'b100, 7'b0000001, 0, 1);
        @(posedge CLK); #1;
        in_valid = 1'b0; fun_3 = 3'b011; opcode = c_LUI;
        for (int i = 0; i < c_DIV_LAT; i++) begin
            @(negedge CLK);
            check_val("div_busy", {a_busy, a_ready, a_valid}, 3'b100);
        end
        drain();

        // MUL stalled three cycles mid-op completes three cycles late.
        issue(c_OP, 3'b000, 7'b0000001, 3, 1);
        @(posedge CLK); #1;
        in_valid = 1'b0; stall_in = 1'b1;
        repeat (3) @(posedge CLK);
        #1 stall_in = 1'b0;
        drain();

        // Flush mid-MULDIV discards the op.
        issue(c_OP, 3'b001, 7'b0000001, 0, 0);
        @(posedge CLK); #1;
        in_valid = 1'b0; flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        @(negedge CLK);
        check_val("flush_idle", {a_valid, a_busy, a_ready}, 3'b001);
        seen = 0;
        repeat (4) begin
            @(negedge CLK);
            if (a_valid) seen++;
        end
        check_val("flush_quiet", seen, 0);

        // M encoding without M extension is illegal.
        issue(c_OP, 3'b000, 7'b0000001, 0, 1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(negedge CLK);
        check_val("mext0_illegal", {b_valid, b_busy, got_b},
                  {2'b10, exp_bundle(c_OP, 3'b000, 7'b0000001, 1'b0)});
        drain();

        // Asynchronous reset between edges aborts a DIV.
        issue(c_OP, 3'b101, 7'b0000001, 0, 0);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        check_val("async_reset", {a_valid, a_busy, got_a}, 0);
        check_val("async_reset_ready", a_ready, 1);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check_val("ready_after_reset", a_ready, 1);
        seen = 0;
        repeat (40) begin
            @(negedge CLK);
            if (a_valid || a_busy) seen++;
        end
        check_val("reset_abort_quiet", seen, 0);
        check_val("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
